// File: rtl/stream_pkg.sv
// Shared widths, FSM state and lane index type for the output-stream packer.
package stream_pkg;
    localparam int WORD_W = 32;
    localparam int BEAT_W = 128;
    localparam int LANES  = 4;

    typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_e;
    typedef logic [1:0] lane_t;
endpackage

// File: rtl/stream_out_packer.sv
// Packs 32-bit result words into 128-bit output beats, padding a short final beat,
// with a one-beat output register, a one-beat holding accumulator and status counters.
module stream_out_packer
    import stream_pkg::*;
#(
    parameter logic [WORD_W-1:0] PAD_WORD = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_rdy,
    output logic              s_valid,
    output logic [BEAT_W-1:0] s_data,
    input  logic              s_rdy,
    output logic [31:0]       beat_count,
    output logic [15:0]       pkt_count,
    output logic              busy
);
    state_e                       state_q;
    lane_t                        lane_q;
    logic [LANES-1:0][WORD_W-1:0] acc_q;
    logic [LANES-1:0][WORD_W-1:0] beat_d;
    logic                         in_rdy_q;
    logic                         s_valid_q;
    logic [BEAT_W-1:0]            s_data_q;
    logic [31:0]                  beat_count_q;
    logic [15:0]                  pkt_count_q;

    logic accept, drain, complete, out_free;

    assign accept   = in_valid && in_rdy_q;
    assign drain    = s_valid_q && s_rdy;
    assign complete = accept && (in_last || lane_q == 2'd3);
    assign out_free = !s_valid_q || s_rdy;

    // Beat as it would look if the current word completes it: earlier lanes
    // from the accumulator, this word in its lane, padding above.
    always_comb begin
        beat_d = acc_q;
        for (int i = 0; i < LANES; i++) begin
            if (i == int'(lane_q))
                beat_d[i] = in_data;
            else if (i > int'(lane_q))
                beat_d[i] = PAD_WORD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FILL;
            lane_q       <= '0;
            acc_q        <= '0;
            in_rdy_q     <= 1'b0;
            s_valid_q    <= 1'b0;
            s_data_q     <= '0;
            beat_count_q <= '0;
            pkt_count_q  <= '0;
        end else begin
            if (drain)
                beat_count_q <= beat_count_q + 32'd1;
            if (accept && in_last)
                pkt_count_q <= pkt_count_q + 16'd1;

            case (state_q)
                FILL: begin
                    in_rdy_q <= 1'b1;
                    if (drain)
                        s_valid_q <= 1'b0;
                    if (accept) begin
                        if (complete) begin
                            lane_q <= '0;
                            if (out_free) begin
                                s_valid_q <= 1'b1;
                                s_data_q  <= beat_d;
                            end else begin
                                // Output register busy: park the finished beat and stall input.
                                acc_q    <= beat_d;
                                state_q  <= HOLD;
                                in_rdy_q <= 1'b0;
                            end
                        end else begin
                            acc_q[lane_q] <= in_data;
                            lane_q        <= lane_q + 2'd1;
                        end
                    end
                end
                HOLD: begin
                    if (drain) begin
                        s_data_q <= acc_q;
                        state_q  <= FILL;
                        in_rdy_q <= 1'b1;
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

    assign in_rdy     = in_rdy_q;
    assign s_valid    = s_valid_q;
    assign s_data     = s_data_q;
    assign beat_count = beat_count_q;
    assign pkt_count  = pkt_count_q;
    assign busy       = s_valid_q || (state_q == HOLD) || (lane_q != 2'd0);
endmodule

// File: tb/tb_stream_out_packer.sv
// Bench for stream_out_packer: vector table, directed corner sequences and a
// randomized run against a word-list reference model.
module tb_stream_out_packer;
    localparam logic [31:0] PAD = 32'hDEAD_BEEF;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic [31:0]  in_data = '0;
    logic         in_last = 1'b0;
    logic         in_rdy;
    logic         s_valid;
    logic [127:0] s_data;
    logic         s_rdy = 1'b0;
    logic [31:0]  beat_count;
    logic [15:0]  pkt_count;
    logic         busy;

    int checks = 0;
    int errors = 0;

    stream_out_packer #(.PAD_WORD(PAD)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_rdy(in_rdy),
        .s_valid(s_valid), .s_data(s_data), .s_rdy(s_rdy),
        .beat_count(beat_count), .pkt_count(pkt_count), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: collect accepted words, cut a beat at 4 words or at last.
    logic [31:0]  part[$];
    logic [127:0] exp_q[$];
    int           mon_beats = 0;
    int           mon_pkts = 0;
    logic         prev_stall = 1'b0;
    logic [127:0] prev_data = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            part.delete();
            exp_q.delete();
            mon_beats = 0;
            mon_pkts = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (!s_valid || s_data !== prev_data) begin
                    errors++;
                    $display("FAIL hold_stable: got v=%0b %h expected v=1 %h", s_valid, s_data, prev_data);
                end
            end
            if (s_valid && s_rdy) begin
                checks++;
                mon_beats++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL out_beat: got %h expected no beat", s_data);
                end else begin
                    if (s_data !== exp_q[0]) begin
                        errors++;
                        $display("FAIL out_beat: got %h expected %h", s_data, exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                end
            end
            if (in_valid && in_rdy) begin
                part.push_back(in_data);
                if (in_last) mon_pkts++;
                if (in_last || part.size() == 4) begin
                    logic [127:0] b;
                    for (int l = 0; l < 4; l++)
                        b[l*32 +: 32] = (l < part.size()) ? part[l] : PAD;
                    exp_q.push_back(b);
                    part.delete();
                end
            end
            prev_stall = s_valid && !s_rdy;
            prev_data  = s_data;
        end
    end

    typedef struct {
        logic         rb;
        logic         iv;
        logic [31:0]  id;
        logic         il;
        logic         sr;
        logic         e_rdy;
        logic         e_sv;
        logic [127:0] e_sd;
        logic         e_cnt;
        logic [31:0]  e_bc;
        logic [15:0]  e_pc;
    } vec_t;
    vec_t vecs[$];

    function automatic void add(input logic rb, input logic iv, input logic [31:0] id,
                                input logic il, input logic sr, input logic e_sv,
                                input logic [127:0] e_sd, input logic e_cnt,
                                input logic [31:0] e_bc, input logic [15:0] e_pc);
        vec_t v;
        v.rb = rb; v.iv = iv; v.id = id; v.il = il; v.sr = sr; v.e_rdy = 1'b1;
        v.e_sv = e_sv; v.e_sd = e_sd; v.e_cnt = e_cnt; v.e_bc = e_bc; v.e_pc = e_pc;
        vecs.push_back(v);
    endfunction

    function automatic logic [127:0] b4(input logic [31:0] w3, input logic [31:0] w2,
                                        input logic [31:0] w1, input logic [31:0] w0);
        return {w3, w2, w1, w0};
    endfunction

    // Leaves the bench at posedge+1 with in_rdy already high.
    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; s_rdy = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0; in_last = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int n_acc;
        logic [31:0] w;
        int sent;
        int spins;
        logic took;

        // Reset state
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("rst_in_rdy", 128'(in_rdy), 128'(0));
        chk("rst_s_valid", 128'(s_valid), 128'(0));
        chk("rst_s_data", s_data, 128'(0));
        chk("rst_beat_count", 128'(beat_count), 128'(0));
        chk("rst_pkt_count", 128'(pkt_count), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("post_rst_in_rdy", 128'(in_rdy), 128'(1));
        @(posedge clk); #1;

        // Table: eight words into two full beats
        add(1, 1, 32'h1, 0, 1, 0, '0, 0, 0, 0);
        add(0, 1, 32'h2, 0, 1, 0, '0, 0, 0, 0);
        add(0, 1, 32'h3, 0, 1, 0, '0, 0, 0, 0);
        add(0, 1, 32'h4, 0, 1, 0, '0, 0, 0, 0);
        add(0, 1, 32'h5, 0, 1, 1, b4(32'h4, 32'h3, 32'h2, 32'h1), 0, 0, 0);
        add(0, 1, 32'h6, 0, 1, 0, '0, 0, 0, 0);
        add(0, 1, 32'h7, 0, 1, 0, '0, 0, 0, 0);
        add(0, 1, 32'h8, 1, 1, 0, '0, 0, 0, 0);
        add(0, 0, 32'h0, 0, 1, 1, b4(32'h8, 32'h7, 32'h6, 32'h5), 0, 0, 0);
        add(0, 0, 32'h0, 0, 1, 0, '0, 1, 2, 1);
        // Two-word packet padded
        add(1, 1, 32'hA, 0, 1, 0, '0, 0, 0, 0);
        add(0, 1, 32'hB, 1, 1, 0, '0, 0, 0, 0);
        add(0, 0, 32'h0, 0, 1, 1, b4(PAD, PAD, 32'hB, 32'hA), 0, 0, 0);
        add(0, 0, 32'h0, 0, 1, 0, '0, 1, 1, 1);
        // Back-to-back single-word packets, beats on consecutive cycles
        add(1, 1, 32'h1, 1, 1, 0, '0, 0, 0, 0);
        add(0, 1, 32'h2, 1, 1, 1, b4(PAD, PAD, PAD, 32'h1), 0, 0, 0);
        add(0, 1, 32'h3, 1, 1, 1, b4(PAD, PAD, PAD, 32'h2), 0, 0, 0);
        add(0, 0, 32'h0, 0, 1, 1, b4(PAD, PAD, PAD, 32'h3), 0, 0, 0);
        add(0, 0, 32'h0, 0, 1, 0, '0, 1, 3, 3);

        foreach (vecs[i]) begin
            if (vecs[i].rb) do_reset();
            in_valid = vecs[i].iv; in_data = vecs[i].id; in_last = vecs[i].il; s_rdy = vecs[i].sr;
            @(negedge clk);
            chk($sformatf("tbl%0d_in_rdy", i), 128'(in_rdy), 128'(vecs[i].e_rdy));
            chk($sformatf("tbl%0d_s_valid", i), 128'(s_valid), 128'(vecs[i].e_sv));
            if (vecs[i].e_sv)
                chk($sformatf("tbl%0d_s_data", i), s_data, vecs[i].e_sd);
            if (vecs[i].e_cnt) begin
                chk($sformatf("tbl%0d_beat_count", i), 128'(beat_count), 128'(vecs[i].e_bc));
                chk($sformatf("tbl%0d_pkt_count", i), 128'(pkt_count), 128'(vecs[i].e_pc));
            end
            @(posedge clk); #1;
        end

        // Backpressure: exactly 8 words accepted with s_rdy low
        do_reset();
        s_rdy = 1'b0; n_acc = 0; w = 32'h100;
        for (int c = 0; c < 14; c++) begin
            in_valid = 1'b1; in_data = w; in_last = 1'b0;
            @(negedge clk);
            took = in_rdy;
            if (took) n_acc++;
            @(posedge clk); #1;
            if (took) w++;
        end
        chk("bp_accepted", 128'(n_acc), 128'(8));
        chk("bp_in_rdy_low", 128'(in_rdy), 128'(0));
        s_rdy = 1'b1; sent = 0;
        for (int c = 0; c < 100 && sent < 8; c++) begin
            in_valid = 1'b1; in_data = w; in_last = (sent == 7);
            @(negedge clk);
            took = in_rdy;
            @(posedge clk); #1;
            if (took) begin w++; sent++; end
        end
        idle(0);
        spins = 0;
        while (busy && spins < 50) begin
            @(posedge clk); #1; spins++;
        end
        chk("bp_drained", 128'(busy), 128'(0));
        chk("bp_queue_empty", 128'(exp_q.size()), 128'(0));
        chk("bp_beat_count", 128'(beat_count), 128'(4));
        chk("bp_pkt_count", 128'(pkt_count), 128'(1));

        // Reset mid-packet
        do_reset();
        s_rdy = 1'b1;
        in_valid = 1'b1; in_data = 32'h55; in_last = 1'b1;
        @(posedge clk); #1;
        in_data = 32'h66; in_last = 1'b0;
        @(posedge clk); #1;
        in_data = 32'h67;
        @(posedge clk); #1;
        rst_n = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("mid_rst_s_valid", 128'(s_valid), 128'(0));
        chk("mid_rst_busy", 128'(busy), 128'(0));
        chk("mid_rst_beat_count", 128'(beat_count), 128'(0));
        chk("mid_rst_pkt_count", 128'(pkt_count), 128'(0));
        chk("mid_rst_in_rdy", 128'(in_rdy), 128'(0));
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        s_rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_data = 32'h11 + 32'(k); in_last = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("mid_rst_clean_valid", 128'(s_valid), 128'(1));
        chk("mid_rst_clean_beat", s_data, b4(32'h14, 32'h13, 32'h12, 32'h11));
        idle(2);

        // Counter wrap from forced preload
        do_reset();
        force dut.beat_count_q = 32'hFFFF_FFFF;
        force dut.pkt_count_q = 16'hFFFF;
        #1;
        release dut.beat_count_q;
        release dut.pkt_count_q;
        s_rdy = 1'b1; in_valid = 1'b1; in_data = 32'h77; in_last = 1'b1;
        @(posedge clk); #1;
        idle(3);
        @(negedge clk);
        chk("wrap_beat_count", 128'(beat_count), 128'(0));
        chk("wrap_pkt_count", 128'(pkt_count), 128'(0));
        @(posedge clk); #1;

        // Randomized traffic against the reference model
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            int ph;
            ph = (c / 250) % 3;
            in_valid = ($urandom % 4) != 0;
            in_data  = $urandom;
            in_last  = ($urandom % 7) == 0;
            case (ph)
                0: s_rdy = ($urandom % 10) != 0;
                1: s_rdy = ($urandom % 10) < 3;
                default: s_rdy = ($urandom % 20) == 0;
            endcase
            @(posedge clk); #1;
        end
        s_rdy = 1'b1;
        took = 1'b0;
        for (int c = 0; c < 20 && !took; c++) begin
            in_valid = 1'b1; in_last = 1'b1; in_data = $urandom;
            @(negedge clk);
            took = in_rdy;
            @(posedge clk); #1;
        end
        chk("rnd_final_accepted", 128'(took), 128'(1));
        idle(0);
        spins = 0;
        while (busy && spins < 50) begin
            @(posedge clk); #1; spins++;
        end
        chk("rnd_drained", 128'(busy), 128'(0));
        chk("rnd_queue_empty", 128'(exp_q.size()), 128'(0));
        chk("rnd_beat_count", 128'(beat_count), 128'(mon_beats));
        chk("rnd_pkt_count", 128'(pkt_count), 128'(mon_pkts));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/stream_out_packer.md
# stream_out_packer

Packs a 32-bit result-word stream from the Smith-Waterman scoring pipeline into 128-bit beats for the host output stream. Sits directly upstream of the output-stream endpoint and drives its `s_valid`/`s_data`/`s_rdy` handshake. Pads a partial final beat at end of packet, and maintains beat and packet counters for host status polling.

## Interface
Parameters:
- `PAD_WORD`, default 32'h0000_0000: fill value for unused lanes of a padded final beat.

Ports:
- `clk` in 1: single clock for the whole block.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `in_valid` in 1: upstream word valid.
- `in_data` in 32: upstream result word.
- `in_last` in 1: qualifies `in_data` as the final word of a packet.
- `in_rdy` out 1: block accepts a word this cycle.
- `s_valid` out 1: output beat valid.
- `s_data` out 128: output beat; lane 0 = bits [31:0], lane 3 = bits [127:96].
- `s_rdy` in 1: downstream accepts a beat.
- `beat_count` out 32: number of beats transferred out.
- `pkt_count` out 16: number of packets whose last word was accepted.
- `busy` out 1: high when the accumulator holds at least one lane or when `s_valid` is high.

## Operation
- Input transfer occurs when `in_valid && in_rdy`. Output transfer occurs when `s_valid && s_rdy`.
- Accumulator: 4×32 register plus a 2-bit lane index `lane`. An accepted word is written to lane `lane`, then `lane` increments.
- A beat completes when the word accepted at lane 3 is accepted, or when any word with `in_last=1` is accepted.
  - On completion, lanes above the written lane are filled with `PAD_WORD`.
  - `lane` then returns to 0.
- The output register holds one beat. A completed beat loads into it when the register is empty or is being drained in the same cycle.
- If the output register is full and not draining, the completed beat stays in the accumulator and the FSM enters HOLD.
- FSM states:
  - FILL: `in_rdy=1`.
  - HOLD: `in_rdy=0`. Moves to FILL in the cycle the output register drains. The held beat loads into the output register on that edge.
- `s_valid` and `s_data` stay stable from assertion until transfer. `s_valid` never depends combinationally on `s_rdy`.
- `beat_count` increments by 1 per output transfer and wraps at 2^32.
- `pkt_count` increments by 1 per accepted word with `in_last=1` and wraps at 2^16.
- `in_last` on lane 3 produces one unpadded beat. `in_last` on lane 0 produces one beat with lanes 1–3 = `PAD_WORD`.
- Reset asserted mid-packet discards the partial accumulator and any pending output beat. There is no flush on reset.

## Timing
- Reset values:
  - `in_rdy=0` while `rst_n=0`, then `in_rdy=1` from the first cycle after release.
  - `s_valid=0`, `s_data=0`.
  - `beat_count=0`, `pkt_count=0`, `busy=0`.
  - FSM in FILL, `lane=0`.
- Latency: completing word accepted at edge N gives `s_valid=1` after edge N, provided the output register was free or draining.
- Throughput: one word per cycle sustained while `s_rdy` is high at least one cycle in every four. One beat per cycle is possible only with back-to-back single-word packets.
- Simultaneous completion and output drain in the same cycle: the new beat loads with no bubble and `s_valid` stays high.
- Backpressure: with `s_rdy` held low, the block accepts exactly 8 words and then drops `in_rdy` (one beat in the output register, one beat in the accumulator).
- `in_rdy` is a registered function of FSM state only. It does not depend on `in_valid`.

## Structure
- Shared package `stream_pkg` holds:
  - `WORD_W=32`, `BEAT_W=128`, `LANES=4`.
  - FSM state enum {FILL, HOLD}.
  - Lane index type (2 bits).
- No sub-module. The accumulator, output register, FSM and counters are all in one module.

## Test plan
- Reset, then 8 words 0x1..0x8 with `s_rdy=1` and `in_last` on 0x8 -> 2 beats: 0x00000004_00000003_00000002_00000001 and 0x00000008_00000007_00000006_00000005. `beat_count=2`, `pkt_count=1`.
- `PAD_WORD`=0xDEADBEEF, 2 words 0xA, 0xB with `in_last` on 0xB -> beat 0xDEADBEEF_DEADBEEF_0000000B_0000000A.
- `s_rdy=0`, stream continuous words -> `in_rdy` falls after the 8th accepted word. Raise `s_rdy` -> beats emerge in order and no word is lost or duplicated.
- Single-word packets 0x1, 0x2, 0x3 back-to-back, each with `in_last=1`, `s_rdy=1` -> 3 beats on consecutive cycles, each padded. `pkt_count=3`.
- Assert `rst_n=0` after 2 words of a packet -> `s_valid=0`, `busy=0`, both counters 0. The next 4 words form a clean beat starting at lane 0.
- Preload `beat_count` to 0xFFFFFFFF (via forced state) and transfer one beat -> `beat_count=0`. Likewise `pkt_count` wraps from 0xFFFF to 0.
